// File: rtl/seg_disp_pkg.sv
// Shared definitions for the display scheduler and its BCD converter.
// Contents:
//   - state_e    : scheduler FSM states.
//   - digit geometry : 6 BCD nibbles of 4 bits each.
//   - DISP_MAX   : largest value the display can show.
//   - SEG_BLANK  : nibble code the seg driver treats as a blank digit.
//   - bcd_adjust : the add-3 correction applied before each double-dabble shift.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int BCD_DIGITS = 6;
  localparam int NIB_W      = 4;
  localparam int BCD_W      = BCD_DIGITS * NIB_W;

  localparam int unsigned DISP_MAX = 999_999;

  localparam logic [NIB_W-1:0] SEG_BLANK = 4'hF;

  // Any nibble >= 5 would become >= 10 after doubling; adding 3 first makes
  // the following shift carry correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic [NIB_W-1:0] nib;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      nib = v[i*NIB_W +: NIB_W];
      if (nib >= NIB_W'(5)) nib = nib + NIB_W'(3);
      r[i*NIB_W +: NIB_W] = nib;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset.
//   start       : load bin_in (saturated to DISP_MAX) and begin converting.
//   bin_in      : binary value, sampled only on start.
//   done        : high in the cycle whose edge performs the final shift.
//   bcd_out     : result of the shift taken on the current edge; complete
//                 and valid when done is high.
//   ovf         : bin_in exceeded DISP_MAX on the last start.
module bin2bcd_seq #(
  parameter int          BIN_W    = 20,
  parameter int unsigned DISP_MAX = seg_disp_pkg::DISP_MAX
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [BIN_W-1:0]               bin_in,
  output logic                           done,
  output logic [seg_disp_pkg::BCD_W-1:0] bcd_out,
  output logic                           ovf
);
  import seg_disp_pkg::*;

  localparam int               CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [BIN_W-1:0] SAT_VAL = BIN_W'(DISP_MAX);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             sat_q, sat_d;
  logic [BCD_W-1:0] bcd_adj;
  logic             last;
  logic             unused_bcd_msb;

  // The MSB of the adjusted BCD is shifted out; it is always 0 for
  // values up to DISP_MAX.
  assign unused_bcd_msb = bcd_adj[BCD_W-1];

  always_comb begin
    bcd_adj = bcd_adjust(bcd_q);
    last    = run_q && (cnt_q == CNT_W'(BIN_W - 1));
    run_d   = run_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    sat_d   = sat_q;
    if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      bcd_d = '0;
      if (32'(bin_in) > 32'(DISP_MAX)) begin
        bin_d = SAT_VAL;
        sat_d = 1'b1;
      end else begin
        bin_d = bin_in;
        sat_d = 1'b0;
      end
    end else if (run_q) begin
      {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
      cnt_d          = cnt_q + 1'b1;
      if (last) run_d = 1'b0;
    end
  end

  assign done    = last;
  assign bcd_out = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign ovf     = sat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  // Working registers: contents are don't-care until the next start.
  always_ff @(posedge clk) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Display scheduler: arbitrates two binary sources (round-robin, req/ack),
// converts the granted value to packed BCD and holds it on screen for at
// least HOLD_MAX+1 cycles before accepting the next request.
// Ports:
//   sys_clk, rst_n   : clock, synchronous active-low reset.
//   req[1:0]         : per-source request, held until the matching ack.
//   bin0, bin1       : source values, stable while requested.
//   ack[1:0]         : one-cycle pulse when the source value is latched.
//   display_val_bcd  : packed BCD for the seg driver, [23:20] = MS digit.
//   active_src       : source of the value currently shown.
//   ovf              : shown value was saturated to DISP_MAX.
//   busy             : conversion or hold in progress.
module seg_disp_sched #(
  parameter int          BIN_W    = 20,
  parameter int unsigned HOLD_MAX = 49_999_999,
  parameter int unsigned DISP_MAX = seg_disp_pkg::DISP_MAX
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [BIN_W-1:0] bin0,
  input  logic [BIN_W-1:0] bin1,
  output logic [1:0]       ack,
  output logic [23:0]      display_val_bcd,
  output logic             active_src,
  output logic             ovf,
  output logic             busy
);
  import seg_disp_pkg::*;

  localparam int HOLD_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              gnt_q, gnt_d;
  logic [1:0]        ack_q, ack_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              src_q, src_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic              gnt;
  logic              conv_start;
  logic              conv_done;
  logic              conv_ovf;
  logic [BCD_W-1:0]  conv_bcd;
  logic              hold_end;

  // A lone request wins outright; a tie goes to the priority pointer.
  assign gnt      = (req == 2'b10) ? 1'b1 : (req == 2'b01) ? 1'b0 : prio_q;
  assign hold_end = (hold_q == HOLD_W'(HOLD_MAX));

  bin2bcd_seq #(
    .BIN_W    (BIN_W),
    .DISP_MAX (DISP_MAX)
  ) u_bin2bcd (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .start   (conv_start),
    .bin_in  (gnt ? bin1 : bin0),
    .done    (conv_done),
    .bcd_out (conv_bcd),
    .ovf     (conv_ovf)
  );

  // State register
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      ack_q   <= 2'b00;
      disp_q  <= '0;
      src_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      disp_q  <= disp_d;
      src_q   <= src_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req != 2'b00) state_d = ST_CONV;
      ST_CONV: if (conv_done)    state_d = ST_HOLD;
      ST_HOLD: if (hold_end)     state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    conv_start = 1'b0;
    prio_d     = prio_q;
    gnt_d      = gnt_q;
    ack_d      = 2'b00;
    disp_d     = disp_q;
    src_d      = src_q;
    ovf_d      = ovf_q;
    hold_d     = hold_q;
    busy_d     = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          conv_start = 1'b1;
          gnt_d      = gnt;
          prio_d     = ~gnt;
          ack_d[gnt] = 1'b1;
        end
      end
      ST_CONV: begin
        // Display, source and overflow change together, only on completion.
        if (conv_done) begin
          disp_d = conv_bcd;
          src_d  = gnt_q;
          ovf_d  = conv_ovf;
          hold_d = '0;
        end
      end
      ST_HOLD: begin
        if (!hold_end) hold_d = hold_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign ack             = ack_q;
  assign display_val_bcd = disp_q;
  assign active_src      = src_q;
  assign ovf             = ovf_q;
  assign busy            = busy_q;

endmodule

// File: doc/seg_disp_sched.md
Name: seg_disp_sched

Overview:
- Display scheduler ahead of the 6-digit seg-scan driver; shares the one display between two binary value sources.
- Arbitrates the sources with a req/ack handshake and a round-robin grant.
- Converts the granted binary value to packed BCD with sequential shift-add-3 (double dabble).
- Drives the driver's 24-bit BCD input and enforces a minimum on-screen hold time per value.

Parameters:
- BIN_W, 20, source value width; also the conversion cycle count.
- HOLD_MAX, 49_999_999, hold counter terminal value; HOLD lasts HOLD_MAX+1 cycles (1 s at 50 MHz).
- DISP_MAX, 999_999, largest displayable value; larger inputs saturate to it.

Ports:
- sys_clk, in, 1, system clock; single clock domain.
- rst_n, in, 1, reset, synchronous, active-low.
- req, in, 2, req[i]=1: source i has a value on bin_i; held until ack[i].
- bin0, in, BIN_W, source 0 value; stable while req[0]=1.
- bin1, in, BIN_W, source 1 value; stable while req[1]=1.
- ack, out, 2, one-cycle pulse on ack[i] when bin_i is latched.
- display_val_bcd, out, 24, packed BCD to seg driver; [23:20] is the MS digit.
- active_src, out, 1, source of the value currently shown.
- ovf, out, 1, current display value was saturated.
- busy, out, 1, 1 in CONV or HOLD.

Behaviour:
- Reset, sampled on the sys_clk edge while rst_n=0:
  - display_val_bcd=24'h0 (driver blanks all digits), ack=0, active_src=0, ovf=0, busy=0.
  - state=IDLE; round-robin priority points to source 0.
- States:
  - IDLE: if req!=0, grant (see arbitration), latch bin into the working register, set ack[g]=1 next cycle, clear the shift counter, go to CONV. Otherwise stay in IDLE.
  - CONV: exactly BIN_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1. After the BIN_W-th shift, in the same edge:
    - display_val_bcd <= bcd result
    - active_src <= g
    - ovf <= saturation flag
    - go to HOLD
  - HOLD: counter runs 0..HOLD_MAX, then go to IDLE. req is ignored in HOLD; the display holds indefinitely while IDLE with no req.
- Arbitration:
  - Only one req set: grant that source.
  - Both set: grant the source named by the priority pointer.
  - After any grant, the pointer moves to the other source.
- Saturation: if the latched value > DISP_MAX, convert DISP_MAX instead and set ovf=1; otherwise ovf=0. ovf changes only with display_val_bcd.
- Timing, with cycle 0 = the edge that samples req in IDLE:
  - ack high during cycle 1 only.
  - display_val_bcd new from cycle BIN_W+1.
  - IDLE re-entered at cycle BIN_W+HOLD_MAX+2; the next request is sampled there.
- busy: 1 from cycle 1 until IDLE is re-entered.
- display_val_bcd never shows a partial conversion; it updates atomically only at CONV end.
- req deassertion:
  - req dropped before sampling: no grant, no ack.
  - req held after ack: treated as a new request at the next IDLE.
- Reset asserted mid-CONV or mid-HOLD: all outputs return to reset values on that edge; the in-flight conversion is discarded.
- Value 0 converts to 24'h000000; the driver's leading-zero blanking handles it.

Decomposition:
- Shared package seg_disp_pkg:
  - state enum (IDLE, CONV, HOLD)
  - BCD_DIGITS=6 and nibble width 4
  - DISP_MAX
  - SEG-side blank code 4'hF
- Sub-module bin2bcd_seq: start/done, sequential double dabble of BIN_W bits into 6 nibbles.
  - Owns the shift counter and saturation compare.
  - The scheduler keeps the FSM, arbitration, hold counter and output registers.

Test Plan (bench sets HOLD_MAX=9):
- Reset, then req=2'b01, bin0=123456 -> ack=2'b01 in cycle 1 only; display_val_bcd=24'h123456 from cycle 21; active_src=0; ovf=0; busy=1 until cycle 31.
- req=2'b10, bin1=20'hFFFFF (1048575) -> display_val_bcd=24'h999999, ovf=1. Next request bin1=7 -> 24'h000007, ovf=0.
- req=2'b11 held continuously, bin0=1, bin1=2 after reset -> grants alternate 0,1,0,1. ack pulses are 31 cycles apart. Display alternates 24'h000001 / 24'h000002.
- HOLD blocking: req[1] raised at cycle 22 while source 0 is in HOLD -> no ack until cycle 31; ack[1] in cycle 32.
- Reset pulse (rst_n=0 one cycle) at cycle 10 of CONV -> next cycle display_val_bcd=0, ack=0, busy=0. A subsequent request converts correctly from scratch.
- bin0=0 -> display_val_bcd=24'h000000 after 21 cycles, ovf=0. bin0=999999 -> 24'h999999, ovf=0.
